reg_load_arb: RTL and testbench
===============================

REG_LOAD_ARB -- requirements
Module: reg_load_arb

Interface
REQ-001 The module SHALL have parameter NREQ, default 3, meaning number of requesters (2..4).
REQ-002 The module SHALL have parameter NREG, default 4, meaning number of 16-bit load-enabled register lanes driven (1..4).
REQ-003 The module SHALL have port sys_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The module SHALL have port req  input  NREQ  per-requester write request; bit i = requester i.
REQ-006 The module SHALL have port addr  input  2*NREQ  target lane per requester; bits [2i+1:2i] = requester i.
REQ-007 The module SHALL have port wdata  input  16*NREQ  write data per requester; bits [16i+15:16i] = requester i.
REQ-008 The module SHALL have port ack  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-009 The module SHALL have port err  output  1  one-cycle pulse, concurrent with ack, when the granted addr >= NREG.
REQ-010 The module SHALL have port ld  output  NREG  one-hot, one-cycle load strobe to register lane k.
REQ-011 The module SHALL have port d  output  16  data presented to all lanes; valid whenever any ld bit is high.
REQ-012 The module SHALL have port busy  output  1  high in every state other than IDLE.
REQ-013 The module SHALL have port gnt_id  output  2  index of the current or most recent winner.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, LOAD, ACK.
REQ-015 In IDLE with any req bit high at an edge, the block SHALL capture the winner index, its addr and its wdata into holding registers and enter LOAD.
REQ-016 In IDLE with req == 0, the block SHALL remain in IDLE.
REQ-017 Arbitration SHALL be round-robin: search starts at (last_winner+1) mod NREQ and wraps, and the first set req bit wins.
REQ-018 last_winner SHALL update only on capture.
REQ-019 In LOAD, ld[held_addr] SHALL be 1 for exactly one cycle and d SHALL equal held data, when held_addr < NREG.
REQ-020 In LOAD with held_addr >= NREG, ld SHALL stay 0.
REQ-021 LOAD SHALL always advance to ACK.
REQ-022 In ACK, ack[held_winner] SHALL be 1 for exactly one cycle, err SHALL equal (held_addr >= NREG), and the next state SHALL be IDLE.
REQ-023 Latency from the capture edge: ld high in cycle +1, ack high in cycle +2; minimum spacing between captures is 3 cycles.
REQ-024 Requesters SHALL hold req, addr and wdata stable until ack is seen and deassert req on the edge at which ack is sampled; the block samples only in IDLE, so req/addr/wdata changes during LOAD/ACK SHALL have no effect.
REQ-025 A requester re-asserting req immediately SHALL lose to any other pending requester (round-robin fairness); with no other request pending, it SHALL win again.
REQ-026 d SHALL hold its last driven value when ld == 0.
REQ-027 ack, ld and err SHALL be registered outputs with no combinational path from any input.

Reset
REQ-028 reset high at an edge SHALL force IDLE, ack=0, ld=0, err=0, busy=0, d=16'h0000, gnt_id=0, last_winner=NREQ-1 (requester 0 highest priority first).
REQ-029 reset in LOAD or ACK SHALL abort the transaction: no ld or ack SHALL follow, and the aborted requester SHALL re-request.
REQ-030 reset SHALL take priority over all other inputs, including a pending req.

Verification
REQ-031 Single write: req=3'b001, addr0=2, wdata0=16'hBEEF -> ld=4'b0100 with d=16'hBEEF in cycle +1; ack=3'b001, err=0 in cycle +2; busy high for 2 cycles.
REQ-032 Contention after reset: req=3'b111 held, each requester dropping on its own ack -> grant order 0,1,2; ack pulses spaced 3 cycles apart.
REQ-033 Fairness: req0 and req2 asserted continuously with immediate re-request -> grants alternate 0,2,0,2 and requester 1 never granted.
REQ-034 Bad address with NREG=3: req1, addr1=3, wdata1=16'h1234 -> ld stays 0 for whole transaction; ack=3'b010 and err=1 in the same cycle.
REQ-035 Reset in LOAD: assert reset in the ld cycle -> ld deasserts next cycle, no ack pulse, all outputs at reset values, next winner is requester 0.
REQ-036 Input change mid-transaction: alter wdata0 from 16'hAAAA to 16'h5555 in the LOAD cycle -> d=16'hAAAA, ack unaffected.

Source files
------------

// File: rtl/reg_load_arb.sv
// Round-robin arbiter that turns per-requester write requests into one-hot,
// one-cycle load strobes on a bank of 16-bit register lanes.
//
// state | meaning
// IDLE  | waiting for any req; captures winner, addr and data
// LOAD  | ld strobe (if addr in range) with d = captured data
// ACK   | ack pulse to the winner, err if addr was out of range
module reg_load_arb #(
  parameter int NREQ = 3,
  parameter int NREG = 4
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    addr,
  input  logic [16*NREQ-1:0]   wdata,
  output logic [NREQ-1:0]      ack,
  output logic                 err,
  output logic [NREG-1:0]      ld,
  output logic [15:0]          d,
  output logic                 busy,
  output logic [1:0]           gnt_id
);

  typedef enum logic [1:0] {IDLE, LOAD, ACK} state_t;

  state_t            state;
  logic [1:0]        last_winner;
  logic [1:0]        held_addr;

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   rot;
  logic [2:0]        off;
  logic [2:0]        sum;
  logic [1:0]        pick;
  logic [1:0]        sel_addr;
  logic [15:0]       sel_data;
  logic              sel_ok;
  logic [NREG-1:0]   ld_next;
  logic [NREQ-1:0]   ack_next;

  // Rotate the request vector so bit 0 is the requester after last_winner;
  // the lowest set bit of the rotated vector is then the round-robin winner.
  always_comb begin
    req_dbl = {req, req};
    rot     = NREQ'(req_dbl >> ({1'b0, last_winner} + 3'd1));
    off     = 3'd0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = 3'(i);
    end
    sum  = {1'b0, last_winner} + 3'd1 + off;
    pick = 2'((sum >= 3'(NREQ)) ? sum - 3'(NREQ) : sum);
  end

  always_comb begin
    sel_addr = 2'd0;
    sel_data = 16'h0000;
    for (int j = 0; j < NREQ; j++) begin
      if (pick == 2'(j)) begin
        sel_addr = addr[2*j +: 2];
        sel_data = wdata[16*j +: 16];
      end
    end
    sel_ok = ({1'b0, sel_addr} < 3'(NREG));
    ld_next = '0;
    for (int k = 0; k < NREG; k++) begin
      ld_next[k] = (sel_addr == 2'(k));
    end
    ack_next = '0;
    for (int i = 0; i < NREQ; i++) begin
      ack_next[i] = (gnt_id == 2'(i));
    end
  end

  // Outputs are set one edge ahead of the state they belong to, so ld is high
  // during LOAD and ack/err during ACK, all straight from flops.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state       <= IDLE;
      last_winner <= 2'(NREQ - 1);
      held_addr   <= 2'd0;
      gnt_id      <= 2'd0;
      ack         <= '0;
      ld          <= '0;
      err         <= 1'b0;
      d           <= 16'h0000;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          err <= 1'b0;
          ld  <= '0;
          if (|req) begin
            gnt_id      <= pick;
            last_winner <= pick;
            held_addr   <= sel_addr;
            ld          <= ld_next;
            if (sel_ok) d <= sel_data;
            busy        <= 1'b1;
            state       <= LOAD;
          end
        end
        LOAD: begin
          ld    <= '0;
          ack   <= ack_next;
          err   <= ({1'b0, held_addr} >= 3'(NREG));
          state <= ACK;
        end
        ACK: begin
          ack   <= '0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ack   <= '0;
          err   <= 1'b0;
          ld    <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_load_arb.sv
// Scoreboard bench for reg_load_arb: directed writes push expected ld/ack
// events; per-instance monitors pop and compare as the DUTs emit them.
module tb_reg_load_arb;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        reset;
  logic [2:0]  req_a, req_b;
  logic [5:0]  addr_a, addr_b;
  logic [47:0] wdata_a, wdata_b;
  logic [2:0]  ack_a, ack_b;
  logic        err_a, err_b;
  logic [3:0]  ld_a;
  logic [2:0]  ld_b;
  logic [15:0] d_a, d_b;
  logic        busy_a, busy_b;
  logic [1:0]  gnt_a, gnt_b;

  reg_load_arb #(.NREQ(3), .NREG(4)) u_dut_a (
    .sys_clk(sys_clk), .reset(reset), .req(req_a), .addr(addr_a), .wdata(wdata_a),
    .ack(ack_a), .err(err_a), .ld(ld_a), .d(d_a), .busy(busy_a), .gnt_id(gnt_a));

  reg_load_arb #(.NREQ(3), .NREG(3)) u_dut_b (
    .sys_clk(sys_clk), .reset(reset), .req(req_b), .addr(addr_b), .wdata(wdata_b),
    .ack(ack_b), .err(err_b), .ld(ld_b), .d(d_b), .busy(busy_b), .gnt_id(gnt_b));

  typedef struct packed {
    logic        is_ack;
    logic [3:0]  ld;
    logic [15:0] d;
    logic [2:0]  ack;
    logic        err;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   ld_cyc_a = 0;
  int   ack_cyc_a = 0;
  int   busy_cnt = 0;
  int   ack_hist[$];

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t ev_ld(input logic [3:0] l, input logic [15:0] dv);
    exp_t e;
    e = '0;
    e.ld = l;
    e.d = dv;
    return e;
  endfunction

  function automatic exp_t ev_ack(input logic [2:0] a, input logic er);
    exp_t e;
    e = '0;
    e.is_ack = 1'b1;
    e.ack = a;
    e.err = er;
    return e;
  endfunction

  // Monitor for the NREG=4 instance
  always @(negedge sys_clk) begin
    busy_cnt += 32'(busy_a);
    if (err_a == 1'b1 && ack_a == 3'b000) chk("a_err_without_ack", 32'(err_a), 32'd0);
    if (ld_a != 4'b0000 || ack_a != 3'b000) begin
      if (ld_a != 4'b0000) ld_cyc_a = cyc;
      if (ack_a != 3'b000) begin
        ack_cyc_a = cyc;
        ack_hist.push_back(cyc);
      end
      if (q_a.size() == 0) begin
        chk("a_unexpected_event", 32'({ack_a, ld_a}), 32'd0);
      end else begin
        ea = q_a.pop_front();
        if (!ea.is_ack) begin
          chk("a_ld", 32'(ld_a), 32'(ea.ld));
          chk("a_d", 32'(d_a), 32'(ea.d));
        end else begin
          chk("a_ack", 32'(ack_a), 32'(ea.ack));
          chk("a_err", 32'(err_a), 32'(ea.err));
        end
      end
    end
  end

  // Monitor for the NREG=3 instance
  always @(negedge sys_clk) begin
    if (err_b == 1'b1 && ack_b == 3'b000) chk("b_err_without_ack", 32'(err_b), 32'd0);
    if (ld_b != 3'b000 || ack_b != 3'b000) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_event", 32'({ack_b, ld_b}), 32'd0);
      end else begin
        eb = q_b.pop_front();
        if (!eb.is_ack) begin
          chk("b_ld", 32'(ld_b), 32'(eb.ld));
          chk("b_d", 32'(d_b), 32'(eb.d));
        end else begin
          chk("b_ack", 32'(ack_b), 32'(eb.ack));
          chk("b_err", 32'(err_b), 32'(eb.err));
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    req_a = '0;
    req_b = '0;
    repeat (2) @(negedge sys_clk);
    reset = 1'b0;
  endtask

  // Waits for n acks on instance A; with drop set, each acked requester
  // releases its req as it sees the ack.
  task automatic serve_a(input int n_acks, input bit drop);
    int seen = 0;
    for (int c = 0; c < 200 && seen < n_acks; c++) begin
      @(negedge sys_clk);
      if (ack_a != 3'b000) begin
        seen++;
        if (drop) req_a = req_a & ~ack_a;
      end
    end
    chk("a_acks_seen", 32'(seen), 32'(n_acks));
  endtask

  task automatic wait_ld_a();
    int got = 0;
    for (int c = 0; c < 50 && got == 0; c++) begin
      @(negedge sys_clk);
      if (ld_a != 4'b0000) got = 1;
    end
    chk("a_ld_wait", 32'(got), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int got;
    reset   = 1'b1;
    req_a   = '0;
    req_b   = '0;
    addr_a  = '0;
    addr_b  = '0;
    wdata_a = '0;
    wdata_b = '0;
    repeat (2) @(negedge sys_clk);
    chk("rst_ack", 32'(ack_a), 32'd0);
    chk("rst_ld", 32'(ld_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_d", 32'(d_a), 32'd0);
    chk("rst_gnt", 32'(gnt_a), 32'd0);
    reset = 1'b0;
    @(negedge sys_clk);

    // Single write: lane 2, BEEF
    q_a.push_back(ev_ld(4'b0100, 16'hBEEF));
    q_a.push_back(ev_ack(3'b001, 1'b0));
    t0 = cyc;
    busy_cnt = 0;
    addr_a[1:0]   = 2'd2;
    wdata_a[15:0] = 16'hBEEF;
    req_a = 3'b001;
    serve_a(1, 1'b1);
    repeat (2) @(negedge sys_clk);
    chk("single_ld_latency", 32'(ld_cyc_a - t0), 32'd1);
    chk("single_ack_latency", 32'(ack_cyc_a - t0), 32'd2);
    chk("single_busy_cycles", 32'(busy_cnt), 32'd2);

    // Contention after reset: grant order 0,1,2
    do_reset();
    addr_a  = {2'd3, 2'd1, 2'd0};
    wdata_a = {16'h3333, 16'h2222, 16'h1111};
    q_a.push_back(ev_ld(4'b0001, 16'h1111));
    q_a.push_back(ev_ack(3'b001, 1'b0));
    q_a.push_back(ev_ld(4'b0010, 16'h2222));
    q_a.push_back(ev_ack(3'b010, 1'b0));
    q_a.push_back(ev_ld(4'b1000, 16'h3333));
    q_a.push_back(ev_ack(3'b100, 1'b0));
    ack_hist.delete();
    req_a = 3'b111;
    serve_a(3, 1'b1);
    @(negedge sys_clk);
    chk("contention_ack_count", 32'(ack_hist.size()), 32'd3);
    if (ack_hist.size() == 3) begin
      chk("contention_spacing_01", 32'(ack_hist[1] - ack_hist[0]), 32'd3);
      chk("contention_spacing_12", 32'(ack_hist[2] - ack_hist[1]), 32'd3);
    end

    // Fairness: req0 and req2 held, grants alternate 0,2,0,2
    do_reset();
    addr_a  = {2'd2, 2'd1, 2'd0};
    wdata_a = {16'h0C0C, 16'h0B0B, 16'h0A0A};
    for (int r = 0; r < 2; r++) begin
      q_a.push_back(ev_ld(4'b0001, 16'h0A0A));
      q_a.push_back(ev_ack(3'b001, 1'b0));
      q_a.push_back(ev_ld(4'b0100, 16'h0C0C));
      q_a.push_back(ev_ack(3'b100, 1'b0));
    end
    req_a = 3'b101;
    serve_a(4, 1'b0);
    req_a = 3'b000;
    repeat (3) @(negedge sys_clk);

    // Bad address on the NREG=3 instance: ack with err, no ld
    q_b.push_back(ev_ack(3'b010, 1'b1));
    addr_b  = {2'd0, 2'd3, 2'd0};
    wdata_b = {16'h0000, 16'h1234, 16'h0000};
    req_b = 3'b010;
    got = 0;
    for (int c = 0; c < 20 && got == 0; c++) begin
      @(negedge sys_clk);
      if (ack_b != 3'b000) begin
        got = 1;
        req_b = 3'b000;
      end
    end
    chk("b_ack_seen", 32'(got), 32'd1);
    repeat (2) @(negedge sys_clk);
    chk("b_d_held", 32'(d_b), 32'd0);

    // Reset during LOAD aborts requester 1; requester 0 wins afterwards
    do_reset();
    addr_a  = {2'd0, 2'd2, 2'd1};
    wdata_a = {16'h0000, 16'h7777, 16'h5A5A};
    q_a.push_back(ev_ld(4'b0010, 16'h5A5A));
    q_a.push_back(ev_ack(3'b001, 1'b0));
    req_a = 3'b001;
    serve_a(1, 1'b1);
    q_a.push_back(ev_ld(4'b0100, 16'h7777));
    req_a = 3'b011;
    wait_ld_a();
    reset = 1'b1;
    @(negedge sys_clk);
    chk("abort_ld", 32'(ld_a), 32'd0);
    chk("abort_ack", 32'(ack_a), 32'd0);
    chk("abort_err", 32'(err_a), 32'd0);
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_d", 32'(d_a), 32'd0);
    chk("abort_gnt", 32'(gnt_a), 32'd0);
    reset = 1'b0;
    q_a.push_back(ev_ld(4'b0010, 16'h5A5A));
    q_a.push_back(ev_ack(3'b001, 1'b0));
    q_a.push_back(ev_ld(4'b0100, 16'h7777));
    q_a.push_back(ev_ack(3'b010, 1'b0));
    serve_a(2, 1'b1);
    repeat (2) @(negedge sys_clk);

    // wdata change during LOAD must not reach d
    do_reset();
    addr_a  = {2'd0, 2'd0, 2'd1};
    wdata_a = {16'h0000, 16'h0000, 16'hAAAA};
    q_a.push_back(ev_ld(4'b0010, 16'hAAAA));
    q_a.push_back(ev_ack(3'b001, 1'b0));
    req_a = 3'b001;
    wait_ld_a();
    wdata_a[15:0] = 16'h5555;
    serve_a(1, 1'b1);
    repeat (2) @(negedge sys_clk);
    chk("midchange_d_held", 32'(d_a), 32'hAAAA);

    chk("q_a_drained", 32'(q_a.size()), 32'd0);
    chk("q_b_drained", 32'(q_b.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
